// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: register enables, bubble
// injection, stall/flush performance counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int unsigned WAIT_W = 16;
  localparam logic [4:0]  XZR    = 5'd31;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic               load_use_c;
  logic               stall_evt_c;
  logic               flush_evt_c;

  // XZR reads as zero, so a load targeting it never blocks a consumer
  assign load_use_c = ex_mem_read && (ex_rd != XZR) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_evt_c   = 1'b0;
    flush_evt_c   = 1'b0;
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b1;
    idex_flush    = 1'b1;

    case (state_q)
      ST_INIT: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (mem_busy) begin
          // Freeze everything; a pending branch is re-presented after the wait
          state_d     = ST_MEM_WAIT;
          stall_evt_c = 1'b1;
          wait_cnt_d  = (wait_cnt_q != '1) ? wait_cnt_q + WAIT_W'(1) : wait_cnt_q;
          if (wait_cnt_d >= WAIT_W'(MEM_TIMEOUT)) mem_timeout_d = 1'b1;
        end else if (ex_branch_taken) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          flush_evt_c = 1'b1;
        end else if (load_use_c) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00111;
          idex_flush  = 1'b1;
          stall_evt_c = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
    endcase

    if (stall_evt_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset/INIT, load-use, squash,
// memory freeze, timeout, async reset mid-freeze and counter saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic mem_timeout;

  logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en, s_ifid_flush, s_idex_flush;
  logic [2:0] s_stall_cnt, s_flush_cnt;
  logic s_mem_timeout;

  logic [6:0] ctl;
  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  pipeline_hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(255)) u_sat (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .mem_timeout(s_mem_timeout)
  );

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ctl !== 7'b0000011) begin failures++; $display("FAIL rst_ctl got=%b exp=%b", ctl, 7'b0000011); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 32'd0) begin failures++; $display("FAIL rst_flush got=%0d exp=0", flush_cnt); end
    checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", mem_timeout); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (ctl !== 7'b0000011) begin failures++; $display("FAIL init_ctl got=%b exp=%b", ctl, 7'b0000011); end
    @(negedge clk); #1;
    checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL run_ctl got=%b exp=%b", ctl, 7'b1111100); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL init_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; #1;
    checks++; if (ctl !== 7'b0011101) begin failures++; $display("FAIL lu_rs2_ctl got=%b exp=%b", ctl, 7'b0011101); end
    @(negedge clk); ex_mem_read = 1'b0; #1;
    checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl, 7'b1111100); end
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL lu_stall1 got=%0d exp=1", stall_cnt); end
    ex_mem_read = 1'b1; ex_rd = 5'd31; id_rs2 = 5'd31; #1;
    checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL lu_xzr_ctl got=%b exp=%b", ctl, 7'b1111100); end
    @(negedge clk);
    id_uses_rs2 = 1'b0; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; #1;
    checks++; if (ctl !== 7'b0011101) begin failures++; $display("FAIL lu_rs1_ctl got=%b exp=%b", ctl, 7'b0011101); end
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL lu_xzr_stall got=%0d exp=1", stall_cnt); end
    @(negedge clk); id_uses_rs1 = 1'b0; #1;
    checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL lu_nouse_ctl got=%b exp=%b", ctl, 7'b1111100); end
    checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL lu_stall2 got=%0d exp=2", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    @(negedge clk);
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; #1;
    checks++; if (ctl !== 7'b1111111) begin failures++; $display("FAIL br_ctl got=%b exp=%b", ctl, 7'b1111111); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (flush_cnt !== 32'd1) begin failures++; $display("FAIL br_flush got=%0d exp=1", flush_cnt); end
    checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL br_stall got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_busy = 1'b1; ex_branch_taken = 1'b1; #1;
      checks++; if (ctl !== 7'b0000000) begin failures++; $display("FAIL frz_ctl[%0d] got=%b exp=%b", i, ctl, 7'b0000000); end
    end
    @(negedge clk); mem_busy = 1'b0; #1;
    checks++; if (ctl !== 7'b1111111) begin failures++; $display("FAIL frz_release_ctl got=%b exp=%b", ctl, 7'b1111111); end
    checks++; if (stall_cnt !== 32'd6) begin failures++; $display("FAIL frz_stall got=%0d exp=6", stall_cnt); end
    checks++; if (flush_cnt !== 32'd1) begin failures++; $display("FAIL frz_noflush got=%0d exp=1", flush_cnt); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (flush_cnt !== 32'd2) begin failures++; $display("FAIL frz_flush got=%0d exp=2", flush_cnt); end
    checks++; if (mem_timeout !== 1'b1) begin failures++; $display("FAIL frz_timeout got=%b exp=1", mem_timeout); end
  endtask

  task automatic test_reset_mid_freeze();
    @(negedge clk); mem_busy = 1'b1;
    @(negedge clk); #1 reset = 1'b1; #1;
    checks++; if (ctl !== 7'b0000011) begin failures++; $display("FAIL mrst_ctl got=%b exp=%b", ctl, 7'b0000011); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL mrst_stall got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 32'd0) begin failures++; $display("FAIL mrst_flush got=%0d exp=0", flush_cnt); end
    checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL mrst_timeout got=%b exp=0", mem_timeout); end
    #1 reset = 1'b0; mem_busy = 1'b0; #1;
    checks++; if (ctl !== 7'b0000011) begin failures++; $display("FAIL mrst_init_ctl got=%b exp=%b", ctl, 7'b0000011); end
    @(negedge clk); #1;
    checks++; if (ctl !== 7'b1111100) begin failures++; $display("FAIL mrst_run_ctl got=%b exp=%b", ctl, 7'b1111100); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL mrst_init_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_timeout();
    mem_busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_timeout !== (k >= 3)) begin
        failures++; $display("FAIL to_edge%0d got=%b exp=%b", k, mem_timeout, (k >= 3));
      end
    end
    @(negedge clk); mem_busy = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", mem_timeout); end
    checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL to_stall got=%0d exp=5", stall_cnt); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", mem_timeout); end
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    mem_busy = 1'b1;
    repeat (9) @(negedge clk);
    mem_busy = 1'b0; ex_branch_taken = 1'b1;
    repeat (9) @(negedge clk);
    clear_inputs(); #1;
    checks++; if (stall_cnt !== 32'd9) begin failures++; $display("FAIL sat_main_stall got=%0d exp=9", stall_cnt); end
    checks++; if (flush_cnt !== 32'd9) begin failures++; $display("FAIL sat_main_flush got=%0d exp=9", flush_cnt); end
    checks++; if (s_stall_cnt !== 3'd7) begin failures++; $display("FAIL sat_stall got=%0d exp=7", s_stall_cnt); end
    checks++; if (s_flush_cnt !== 3'd7) begin failures++; $display("FAIL sat_flush got=%0d exp=7", s_flush_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_freeze();
    test_reset_mid_freeze();
    test_timeout();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage CPU. Each cycle it generates the write enables and bubble/flush controls for the PC register and the four 64-bit-per-field pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), which are built from enabled D-flip-flop register banks. It resolves three hazards:
- load-use stalls;
- taken-branch squashes;
- data-memory wait freezes.

It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters
- MEM_TIMEOUT, 255, number of consecutive mem_busy cycles that sets mem_timeout (legal range 1 to 2^16-1)

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high
- id_rs1  in  5  first source register of the instruction in ID
- id_rs2  in  5  second source register of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads id_rs1
- id_uses_rs2  in  1  ID instruction reads id_rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_busy  in  1  data memory not ready this cycle
- pc_en  out  1  PC register write enable
- ifid_en  out  1  IF/ID register enable
- idex_en  out  1  ID/EX register enable
- exmem_en  out  1  EX/MEM register enable
- memwb_en  out  1  MEM/WB register enable
- ifid_flush  out  1  IF/ID loads a bubble (NOP) instead of its data
- idex_flush  out  1  ID/EX loads a bubble instead of its data
- stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN or MEM_WAIT; saturating
- flush_cnt  out  CNT_W  taken-branch squash events; saturating
- mem_timeout  out  1  sticky error flag

## Operation
FSM states: INIT, RUN, MEM_WAIT.

INIT
- Entered asynchronously while reset=1.
- Held for exactly one clock after reset deasserts, then moves to RUN.
- Outputs: all enables 0; ifid_flush=1 and idex_flush=1 (both enables are 0, so only the flush level is defined here).

RUN and MEM_WAIT share one priority decode, highest priority first:
1. mem_busy=1 (freeze)
   - All five enables 0; both flushes 0.
   - Next state is MEM_WAIT.
2. ex_branch_taken=1 (squash)
   - All enables 1; ifid_flush=1; idex_flush=1.
   - flush_cnt increments.
3. Load-use hazard
   - Condition: ex_mem_read=1, ex_rd≠31, and (id_uses_rs1 and id_rs1==ex_rd, or id_uses_rs2 and id_rs2==ex_rd).
   - Outputs: pc_en=0; ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=1; memwb_en=1.
4. Otherwise: all enables 1; both flushes 0.

Rules:
- Register 31 (XZR) never creates a hazard.
- Load-use stalls last one cycle. The bubble clears ex_mem_read on the next cycle, so no extra state is used.
- Branch outranks load-use because the dependent instruction is being squashed.
- mem_busy outranks branch. EX is frozen, so ex_branch_taken is presented again after the freeze and the squash happens then; no flush occurs during the freeze.
- MEM_WAIT returns to RUN on the first cycle with mem_busy=0. That cycle is decoded as RUN in the same cycle, with no dead cycle.

Wait counter (16-bit wait_cnt):
- Cleared in INIT and RUN.
- Increments each cycle that mem_busy=1.
- When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set. It stays set (sticky) until reset.
- wait_cnt saturates and the freeze continues.

Performance counters:
- Saturate at all-ones; they do not wrap.
- Change only at posedge clk.

## Timing
- Control outputs (enables and flushes) are combinational (Mealy) from the current state and inputs, with zero-cycle latency. The pipeline registers act on them at the same posedge.
- State, wait_cnt, stall_cnt, flush_cnt and mem_timeout update on posedge clk.

Reset values (reset=1, asynchronous):
- state=INIT, all enables 0, ifid_flush=1, idex_flush=1.
- stall_cnt=0, flush_cnt=0, mem_timeout=0, wait_cnt=0.

Reset asserted mid-stall or mid-freeze:
- Jumps to INIT immediately without waiting for a clock edge.
- Counters clear.
- After reset releases, one INIT cycle follows, then RUN.

stall_cnt:
- Counts freeze cycles and load-use cycles.
- Does not count INIT.

## Test plan
- Reset, then release → one cycle with all enables 0 and both flushes 1, then all enables 1 and flushes 0; counters read 0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; next cycle normal; stall_cnt=1. Repeat with ex_rd=31 → no stall.
- ex_branch_taken=1 together with a load-use match → all enables 1, ifid_flush=1, idex_flush=1; flush_cnt=1; stall_cnt unchanged.
- mem_busy=1 for 4 cycles with ex_branch_taken=1 held → all enables 0 and no flush for 4 cycles; on cycle 5 (mem_busy=0) squash asserted; stall_cnt=4; flush_cnt=1.
- MEM_TIMEOUT=3 and mem_busy held for 5 cycles → mem_timeout rises after the 3rd busy edge and stays 1 after mem_busy drops, until reset.
- Assert reset for a fraction of a cycle during MEM_WAIT → outputs go to reset values immediately; counters 0; INIT then RUN.
